// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue.
//   NOP_INST      : instruction placed in fault entries (addi x0, x0, 0)
//   fetch_entry_t : one queued fetch result {pc, inst, fault}
//   fetch_state_e : fetch FSM states
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    FETCH,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush.
//   clk, reset      : clock, synchronous active-high reset
//   flush           : drop all entries and reset pointers (overrides push/pop)
//   push, push_data : write one entry at the tail
//   pop             : retire the head entry
//   full, empty     : occupancy flags
//   head            : head entry, forced to zero while empty
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] rd_q, wr_q;
  logic [PtrW:0]   count_q, count_d;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: head is masked while empty.
  // Push+pop when full writes the slot being retired, which becomes the new tail.
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) mem_q[wr_q] <= push_data;
  end

  assign full  = (count_q == (PtrW + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = empty ? '0 : mem_q[rd_q];

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage in front of the instruction ROM. Owns the PC, fetches one word per
// cycle into a small queue and hands entries to decode over valid/ready.
//   clk, reset                 : clock, synchronous active-high reset
//   rom_addr / rom_inst        : combinational ROM lookup (rom_addr = pc[11:0])
//   redirect_valid/redirect_pc : load new PC and flush the queue
//   out_valid/out_ready        : decode handshake for the head entry
//   out_pc/out_inst/out_fault  : head entry contents
//   halted                     : fetch stopped after a fault, waiting for redirect
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned ROM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  output logic [11:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault,
  output logic        halted
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         push, pop, flush, full, empty, fault;
  fetch_entry_t push_data, head;

  assign fault = (pc_q[1:0] != 2'b00) || (pc_q >= 32'(ROM_BYTES));

  // A redirect cancels any dequeue in the same cycle.
  assign pop = out_valid && out_ready && !redirect_valid;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    push      = 1'b0;
    flush     = 1'b0;
    push_data = '0;
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_d    = redirect_pc;
      state_d = FETCH;
    end else if (state_q == FETCH && (!full || pop)) begin
      push         = 1'b1;
      push_data.pc = pc_q;
      if (fault) begin
        push_data.inst  = NOP_INST;
        push_data.fault = 1'b1;
        state_d         = HALT;
      end else begin
        push_data.inst = rom_inst;
        pc_d           = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  assign rom_addr  = pc_q[11:0];
  assign out_valid = !empty;
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
  assign out_fault = head.fault;
  assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: a vector table plus a few multi-cycle sequences.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        reset, redirect_valid, out_ready;
  logic [31:0] redirect_pc, rom_inst;
  logic [11:0] rom_addr;
  logic        out_valid, out_fault, halted;
  logic [31:0] out_pc, out_inst;

  always #5 clk = ~clk;

  // ROM model: word i holds 0x100 + i.
  assign rom_inst = 32'h100 + {22'b0, rom_addr[11:2]};

  inst_fetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_fault      (out_fault),
    .halted         (halted)
  );

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic        ef;
    logic        eh;
    logic [11:0] eaddr;
  } vec_t;

  vec_t vq[$];
  int   passed = 0;
  int   total  = 0;

  task automatic add(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic ev, input logic [31:0] epc, input logic [31:0] einst,
                     input logic ef, input logic eh, input logic [11:0] eaddr);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.einst = einst; v.ef = ef; v.eh = eh; v.eaddr = eaddr;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [31:0] epc,
                           input logic [31:0] einst, input logic ef, input logic eh,
                           input logic [11:0] eaddr);
    check({tag, "_valid"}, {31'b0, out_valid}, {31'b0, ev});
    check({tag, "_pc"}, out_pc, epc);
    check({tag, "_inst"}, out_inst, einst);
    check({tag, "_fault"}, {31'b0, out_fault}, {31'b0, ef});
    check({tag, "_halted"}, {31'b0, halted}, {31'b0, eh});
    check({tag, "_addr"}, {20'b0, rom_addr}, {20'b0, eaddr});
  endtask

  initial begin
    int n;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

    //   rst rv rpc          rdy  ev pc           inst         f  h  addr
    // Reset, then streaming with out_ready=1.
    add(1, 0, 32'h0,       1,   0, 32'h0,       32'h0,       0, 0, 12'h000);
    add(1, 0, 32'h0,       1,   0, 32'h0,       32'h0,       0, 0, 12'h000);
    add(0, 0, 32'h0,       1,   1, 32'h0,       32'h100,     0, 0, 12'h004);
    add(0, 0, 32'h0,       1,   1, 32'h4,       32'h101,     0, 0, 12'h008);
    add(0, 0, 32'h0,       1,   1, 32'h8,       32'h102,     0, 0, 12'h00C);
    // Reset again, then stall 5 cycles: queue fills with pc 0,4 and pc parks at 8.
    add(1, 0, 32'h0,       0,   0, 32'h0,       32'h0,       0, 0, 12'h000);
    add(0, 0, 32'h0,       0,   1, 32'h0,       32'h100,     0, 0, 12'h004);
    add(0, 0, 32'h0,       0,   1, 32'h0,       32'h100,     0, 0, 12'h008);
    add(0, 0, 32'h0,       0,   1, 32'h0,       32'h100,     0, 0, 12'h008);
    add(0, 0, 32'h0,       0,   1, 32'h0,       32'h100,     0, 0, 12'h008);
    add(0, 0, 32'h0,       0,   1, 32'h0,       32'h100,     0, 0, 12'h008);
    // Release: drain 0 -> 4 -> 8 while full push+pop keeps fetching.
    add(0, 0, 32'h0,       1,   1, 32'h4,       32'h101,     0, 0, 12'h00C);
    add(0, 0, 32'h0,       1,   1, 32'h8,       32'h102,     0, 0, 12'h010);
    add(0, 0, 32'h0,       0,   1, 32'h8,       32'h102,     0, 0, 12'h010);
    // Redirect to 0x40 with a full queue and out_ready high.
    add(0, 1, 32'h40,      1,   0, 32'h0,       32'h0,       0, 0, 12'h040);
    add(0, 0, 32'h0,       1,   1, 32'h40,      32'h110,     0, 0, 12'h044);
    add(0, 0, 32'h0,       1,   1, 32'h44,      32'h111,     0, 0, 12'h048);
    // Misaligned redirect: one fault entry, halt, then resume via redirect to 0.
    add(0, 1, 32'h42,      1,   0, 32'h0,       32'h0,       0, 0, 12'h042);
    add(0, 0, 32'h0,       1,   1, 32'h42,      32'h13,      1, 1, 12'h042);
    add(0, 0, 32'h0,       1,   0, 32'h0,       32'h0,       0, 1, 12'h042);
    add(0, 0, 32'h0,       1,   0, 32'h0,       32'h0,       0, 1, 12'h042);
    add(0, 1, 32'h0,       1,   0, 32'h0,       32'h0,       0, 0, 12'h000);
    add(0, 0, 32'h0,       1,   1, 32'h0,       32'h100,     0, 0, 12'h004);
    // End of ROM: 0xFFC is good, 0x1000 is out of range.
    add(0, 1, 32'hFF8,     1,   0, 32'h0,       32'h0,       0, 0, 12'hFF8);
    add(0, 0, 32'h0,       1,   1, 32'hFF8,     32'h4FE,     0, 0, 12'hFFC);
    add(0, 0, 32'h0,       1,   1, 32'hFFC,     32'h4FF,     0, 0, 12'h000);
    add(0, 0, 32'h0,       1,   1, 32'h1000,    32'h13,      1, 1, 12'h000);
    add(0, 0, 32'h0,       1,   0, 32'h0,       32'h0,       0, 1, 12'h000);
    // Reset wins over a simultaneous redirect.
    add(1, 1, 32'h80,      1,   0, 32'h0,       32'h0,       0, 0, 12'h000);
    add(0, 0, 32'h0,       1,   1, 32'h0,       32'h100,     0, 0, 12'h004);

    foreach (vq[i]) begin
      reset = vq[i].rst; redirect_valid = vq[i].rv; redirect_pc = vq[i].rpc;
      out_ready = vq[i].rdy;
      step();
      check_all($sformatf("v%0d", i), vq[i].ev, vq[i].epc, vq[i].einst, vq[i].ef, vq[i].eh,
                vq[i].eaddr);
    end

    // Sustained throughput: one instruction per cycle after reset.
    reset = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("tput%0d_pc", i), out_pc, 32'(4 * i));
      check($sformatf("tput%0d_inst", i), out_inst, 32'h100 + 32'(i));
    end

    // Redirect latency: first target entry two cycles after the pulse.
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 6) begin
      step();
      n++;
    end
    check("redir_latency", 32'(n), 32'd2);
    check("redir_pc", out_pc, 32'h20);
    check("redir_inst", out_inst, 32'h108);

    // Fault head held stable while decode stalls; no further fetches in HALT.
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h3;
    step();
    redirect_valid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check_all($sformatf("hold%0d", i), 1'b1, 32'h3, 32'h13, 1'b1, 1'b1, 12'h003);
    end
    out_ready = 1'b1;
    step();
    check_all("drained", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 12'h003);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Fetch stage directly upstream of the instruction ROM.
- Owns the PC and drives the ROM's combinational word address (12-bit byte address, word index = addr>>2).
- Captures each returned instruction into a small FIFO together with its PC, and presents entries to decode over a valid/ready handshake.
- Handles redirects (branch/jump/trap) by flushing the queue, and flags misaligned or out-of-range fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, queue entries; power of two, at least 2.
- ROM_BYTES, 4096, fetchable byte range; a PC at or above this value is out of range.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rom_addr  out  12  byte address to ROM; always equals pc[11:0].
- rom_inst  in  32  combinational ROM data for rom_addr, valid in the same cycle.
- redirect_valid  in  1  one-cycle pulse; load new PC and flush.
- redirect_pc  in  32  redirect target.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode accepts the head entry.
- out_pc  out  32  PC of the head entry.
- out_inst  out  32  instruction of the head entry (32'h0000_0013 when out_fault=1).
- out_fault  out  1  head entry is a fetch fault (misaligned or out of range).
- halted  out  1  fetch stopped after a fault; waits for a redirect.

Behaviour:
- Reset (synchronous, checked before everything else):
  - pc = RESET_PC, queue empty, halted = 0.
  - out_valid = 0; out_pc, out_inst and out_fault = 0.
  - Reset overrides a simultaneous redirect.
- State machine, two states:
  - FETCH, entered on reset or on redirect.
  - HALT, entered on fault enqueue; halted = (state == HALT).
- Fetch condition: state FETCH, no redirect this cycle, and (count < DEPTH or a dequeue occurs this cycle).
- When the fetch condition holds:
  - Good PC: enqueue {pc, rom_inst, fault=0} and set pc = pc + 4, 32-bit wrap.
  - Fault PC (pc[1:0] != 0 or pc >= ROM_BYTES): enqueue {pc, 32'h13, fault=1}, pc holds, next state HALT.
- Dequeue when out_valid && out_ready; the head pointer advances.
- Enqueue and dequeue in the same cycle with the queue full is allowed; count is unchanged.
- Queue outputs are registered FIFO head outputs:
  - An instruction fetched in cycle N is visible on out_* in cycle N+1.
  - Fetch-to-decode latency is 1 cycle.
  - Sustained throughput is 1 instruction per cycle while out_ready = 1.
- Redirect (highest priority after reset):
  - Queue is flushed: count = 0 and pointers reset.
  - pc = redirect_pc; state = FETCH.
  - No enqueue and no dequeue that cycle.
  - out_valid = 0 in the following cycle.
  - First redirected instruction appears 2 cycles after the redirect pulse.
- Redirect together with out_ready: the dequeue is discarded. Decode must treat the cycle as a flush.
- Outputs are stable while out_valid && !out_ready. The head does not change.
- In HALT, no fetches occur. Queued entries, including the fault entry, still drain normally.
- rom_addr follows pc combinationally from the register. No combinational path from redirect_pc to rom_addr.
- Pointers wrap modulo DEPTH. count has width $clog2(DEPTH)+1.

Decomposition:
- Package fetch_pkg holds:
  - NOP_INST = 32'h0000_0013.
  - typedef fetch_entry_t: struct of pc[31:0], inst[31:0], fault.
  - enum fetch_state_e {FETCH, HALT}.
- One sub-module, fetch_fifo: a parameterised synchronous FIFO of fetch_entry_t with flush, push, pop, full, empty and head outputs.
- The top-level module keeps the PC, FSM, fault detection and redirect priority.

Test Plan:
- Reset release, ROM word i = 32'h100+i, out_ready=1: out_pc = 0, 4, 8, … and out_inst = 0x100, 0x101, … in consecutive cycles; first out_valid one cycle after the first fetch.
- out_ready=0 for 5 cycles after startup: queue holds 2 entries (pc 0, 4); pc stops at 8; out_pc stays 0. On release, entries drain in order 0, 4, 8 with no loss.
- Redirect to 0x40 with a full queue: next cycle out_valid=0; the cycle after, out_pc=0x40 with out_inst = ROM word 16; stale pc 0/4 never appear.
- Redirect to 0x42 (misaligned): one entry with out_pc=0x42, out_fault=1, out_inst=0x13; halted=1; no further entries; a redirect to 0x0 resumes fetching and clears halted.
- Sequential fetch reaches pc = 0xFFC then 0x1000: word 1023 delivered normally; pc 0x1000 delivered as fault=1, halted=1.
- Redirect asserted together with reset: state equals plain reset (pc=RESET_PC, queue empty); redirect ignored.
